// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
// Bundle of the load-port and fetch-port signals of instr_mem_loader.
//   slave  : the memory side (drives load_ready, instruction, instr_valid,
//            prog_len, loaded, overflow).
//   master : the producer / CPU side (drives clear, load_*, fetch_*).
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              clear;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic [ADDR_W:0]   prog_len;
  logic              loaded;
  logic              overflow;

  modport master (
    output clear, load_start, load_valid, load_data, load_last,
           fetch_req, fetch_addr,
    input  load_ready, instruction, instr_valid, prog_len, loaded, overflow
  );

  modport slave (
    input  clear, load_start, load_valid, load_data, load_last,
           fetch_req, fetch_addr,
    output load_ready, instruction, instr_valid, prog_len, loaded, overflow
  );
endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Loadable instruction memory for the CPU fetch stage. A program is streamed
// in through a valid/ready load port; fetches return one word per cycle with
// one cycle of latency. Unloaded or out-of-range addresses return FILL_WORD so
// a runaway CPU fetches STOP.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : instr_mem_loader_if.slave (load port, fetch port, status)
// DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_W.
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(8'b11000011)
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_mem_loader_if.slave  bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // wr_ptr counts up to DEPTH inclusive, hence ADDR_W+1 bits
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic              r_overflow;
  logic              r_instr_valid;
  logic              r_sel_mem;     // last fetch hit the loaded program
  logic [DATA_W-1:0] r_ram_q;       // registered RAM read port
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_load_ready;
  logic              w_accept;
  logic              w_store;
  logic              w_fetch_hit;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  // ---------------------------------------------------------------------------
  // Load-port qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    // clear and load_start both pre-empt a beat offered in the same cycle
    w_load_ready = (r_state == S_LOADING) && !bus.clear && !bus.load_start;
    w_accept     = bus.load_valid && w_load_ready;
    // once wr_ptr reaches DEPTH the beat is drained, not stored
    w_store      = w_accept && (r_wr_ptr < DEPTH_C);
    // fetch decisions use the state before any transition in this cycle
    w_fetch_hit  = (r_state == S_READY) &&
                   ({1'b0, bus.fetch_addr} < r_prog_len);
    w_wr_idx     = r_wr_ptr[IDX_W-1:0];
    w_rd_idx     = bus.fetch_addr[IDX_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = S_EMPTY;
    end else if (bus.load_start) begin
      // from any state, including a restart while already loading
      w_state_next = S_LOADING;
    end else if (w_accept && bus.load_last) begin
      w_state_next = S_READY;
    end
  end

  // ---------------------------------------------------------------------------
  // Load bookkeeping and fetch control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_prog_len    <= '0;
      r_overflow    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_sel_mem     <= 1'b0;
    end else begin
      r_instr_valid <= bus.fetch_req;
      // without a request the selector holds, so instruction holds too
      if (bus.fetch_req) begin
        r_sel_mem <= w_fetch_hit;
      end

      if (bus.clear || bus.load_start) begin
        r_wr_ptr   <= '0;
        r_prog_len <= '0;
        r_overflow <= 1'b0;
      end else if (w_accept) begin
        if (w_store) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
        if (bus.load_last) begin
          r_prog_len <= w_store ? (r_wr_ptr + 1'b1) : DEPTH_C;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: no reset so it maps onto block RAM. Writes only happen while
  // LOADING and reads only matter while READY, so there is no read/write
  // collision to resolve.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_wr_idx] <= bus.load_data;
    end
    if (bus.fetch_req) begin
      r_ram_q <= r_mem[w_rd_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.load_ready  = w_load_ready;
  // after reset r_sel_mem=0, so instruction shows FILL_WORD
  assign bus.instruction = r_sel_mem ? r_ram_q : FILL_WORD;
  assign bus.instr_valid = r_instr_valid;
  assign bus.prog_len    = r_prog_len;
  assign bus.loaded      = (r_state == S_READY);
  assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader (DATA_W=8, ADDR_W=8, DEPTH=32).
// A reference model holds the stored program as a queue of words and checks
// every output every cycle; directed sequences add fixed expectations.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int         DATA_W = 8;
  localparam int         ADDR_W = 8;
  localparam int         DEPTH  = 32;
  localparam logic [7:0] FILL   = 8'hC3;

  typedef struct {
    logic       clr;
    logic       st;
    logic       v;
    logic [7:0] d;
    logic       lst;
    logic       fr;
    logic [7:0] fa;
  } in_t;

  typedef struct {
    logic [7:0] fa;
    logic [7:0] exp_instr;
  } fvec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  instr_mem_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .FILL_WORD(FILL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_loading;   // a load is in progress
  bit         m_ready;     // a complete program is held
  bit         m_ovf;
  logic [7:0] m_prog[$];   // words stored by the current load
  int         m_len;       // reported program length
  logic [7:0] m_instr;
  bit         m_ivalid;

  task automatic model_reset();
    m_loading = 0;
    m_ready   = 0;
    m_ovf     = 0;
    m_prog.delete();
    m_len     = 0;
    m_instr   = FILL;
    m_ivalid  = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t vin(input logic clr, input logic st, input logic v,
                              input logic [7:0] d, input logic lst,
                              input logic fr, input logic [7:0] fa);
    in_t x;
    x.clr = clr; x.st = st; x.v = v; x.d = d; x.lst = lst; x.fr = fr; x.fa = fa;
    return x;
  endfunction

  function automatic in_t idle();
    return vin(0, 0, 0, 8'h00, 0, 0, 8'h00);
  endfunction

  function automatic in_t fetch(input logic [7:0] fa);
    return vin(0, 0, 0, 8'h00, 0, 1, fa);
  endfunction

  function automatic in_t beat(input logic [7:0] d, input logic lst);
    return vin(0, 0, 1, d, lst, 0, 8'h00);
  endfunction

  // One clock cycle: drive at negedge, check load_ready, step the model at
  // posedge, then check registered outputs 1 time unit later.
  task automatic cycle(input in_t x, input bit verbose);
    bit exp_ready;
    bit accepted;
    @(negedge clk);
    bus.clear      = x.clr;
    bus.load_start = x.st;
    bus.load_valid = x.v;
    bus.load_data  = x.d;
    bus.load_last  = x.lst;
    bus.fetch_req  = x.fr;
    bus.fetch_addr = x.fa;
    #1;
    exp_ready = m_loading && !x.clr && !x.st;
    chk("load_ready", bus.load_ready, exp_ready);
    @(posedge clk);
    accepted = exp_ready && x.v;
    if (x.fr) begin
      m_ivalid = 1;
      m_instr  = (m_ready && int'(x.fa) < m_prog.size()) ? m_prog[x.fa] : FILL;
    end else begin
      m_ivalid = 0;
    end
    if (x.clr) begin
      m_loading = 0; m_ready = 0; m_ovf = 0; m_prog.delete(); m_len = 0;
    end else if (x.st) begin
      m_loading = 1; m_ready = 0; m_ovf = 0; m_prog.delete(); m_len = 0;
    end else if (accepted) begin
      if (m_prog.size() < DEPTH) m_prog.push_back(x.d);
      else                       m_ovf = 1;
      if (x.lst) begin
        m_loading = 0; m_ready = 1; m_len = m_prog.size();
      end
    end
    #1;
    chk("instruction", bus.instruction, m_instr);
    chk("instr_valid", bus.instr_valid, m_ivalid);
    chk("prog_len",    bus.prog_len,    m_len);
    chk("loaded",      bus.loaded,      m_ready);
    chk("overflow",    bus.overflow,    m_ovf);
    if (verbose)
      $display("cyc clr=%0d st=%0d v=%0d d=%02h last=%0d fr=%0d fa=%0d -> instr=%02h iv=%0d len=%0d loaded=%0d ovf=%0d",
               x.clr, x.st, x.v, x.d, x.lst, x.fr, x.fa, bus.instruction,
               bus.instr_valid, bus.prog_len, bus.loaded, bus.overflow);
  endtask

  fvec_t ftab[7];
  logic [7:0] pat[4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pat[0] = 8'h45; pat[1] = 8'h59; pat[2] = 8'h6D; pat[3] = 8'h71;
    ftab[0] = '{8'd0,   8'h45};
    ftab[1] = '{8'd1,   8'h59};
    ftab[2] = '{8'd28,  8'hC3};
    ftab[3] = '{8'd29,  8'hC3};
    ftab[4] = '{8'd200, 8'hC3};
    ftab[5] = '{8'd3,   8'h71};
    ftab[6] = '{8'd4,   8'h45};

    bus.clear = 0; bus.load_start = 0; bus.load_valid = 0; bus.load_data = 0;
    bus.load_last = 0; bus.fetch_req = 0; bus.fetch_addr = 0;
    rst_n = 0;
    model_reset();

    // 1. reset values
    repeat (2) @(negedge clk);
    chk("rst_instruction", bus.instruction, FILL);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_prog_len",    bus.prog_len,    0);
    chk("rst_loaded",      bus.loaded,      0);
    chk("rst_overflow",    bus.overflow,    0);
    chk("rst_load_ready",  bus.load_ready,  0);
    rst_n = 1;
    cycle(fetch(8'd0), 1);
    chk("t1_fetch0", bus.instruction, 8'hC3);
    chk("t1_valid",  bus.instr_valid, 1);
    chk("t1_loaded", bus.loaded,      0);
    cycle(idle(), 1);
    chk("t1_valid_drop", bus.instr_valid, 0);

    // 2. load 29 beats
    cycle(vin(0, 1, 0, 8'h00, 0, 0, 8'h00), 1);
    for (int i = 0; i < 28; i++) cycle(beat(pat[i % 4], 0), 1);
    cycle(beat(8'hC3, 1), 1);
    chk("t2_loaded",   bus.loaded,   1);
    chk("t2_prog_len", bus.prog_len, 29);

    // 2/3. table of fetches, applied back to back
    for (int i = 0; i < 7; i++) begin
      cycle(fetch(ftab[i].fa), 1);
      chk("tab_instr", bus.instruction, ftab[i].exp_instr);
      chk("tab_valid", bus.instr_valid, 1);
    end
    cycle(idle(), 1);
    chk("t3_hold", bus.instruction, 8'h45);

    // 4. overflow: 40 beats with valid gaps, drain keeps load_ready high
    cycle(vin(0, 1, 0, 8'h00, 0, 0, 8'h00), 1);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 1) cycle(idle(), 1);
      cycle(beat(8'(i), i == 39), 1);
      if (i >= 32 && i < 39) chk("t4_drain_ready", bus.load_ready, 1);
    end
    chk("t4_prog_len", bus.prog_len, 32);
    chk("t4_overflow", bus.overflow, 1);
    cycle(fetch(8'd31), 1);
    chk("t4_fetch31", bus.instruction, 8'd31);

    // 5. clear after 10 beats (clear beats a simultaneous beat)
    cycle(vin(0, 1, 0, 8'h00, 0, 0, 8'h00), 1);
    for (int i = 0; i < 10; i++) cycle(beat(8'h80 + 8'(i), 0), 1);
    cycle(vin(1, 0, 1, 8'hEE, 0, 0, 8'h00), 1);
    chk("t5_prog_len", bus.prog_len, 0);
    chk("t5_ready",    bus.load_ready, 0);
    chk("t5_loaded",   bus.loaded,   0);
    cycle(vin(0, 0, 1, 8'h12, 1, 1, 8'd0), 1);
    chk("t5_fetch0", bus.instruction, 8'hC3);
    chk("t5_ignored", bus.loaded, 0);

    // 6. reload while READY; fetch alongside load_start sees old program
    cycle(vin(0, 1, 0, 8'h00, 0, 0, 8'h00), 1);
    cycle(beat(8'h11, 0), 1);
    cycle(beat(8'h22, 0), 1);
    cycle(beat(8'h33, 1), 1);
    cycle(vin(0, 1, 0, 8'h00, 0, 1, 8'd0), 1);
    chk("t6_prestate_fetch", bus.instruction, 8'h11);
    cycle(vin(0, 0, 1, 8'hAA, 0, 1, 8'd0), 1);
    chk("t6_fetch_loading", bus.instruction, 8'hC3);
    cycle(beat(8'hBB, 1), 1);
    chk("t6_prog_len", bus.prog_len, 2);
    cycle(fetch(8'd2), 1);
    chk("t6_fetch2", bus.instruction, 8'hC3);
    cycle(fetch(8'd1), 1);
    chk("t6_fetch1", bus.instruction, 8'hBB);

    // reset asserted mid-load
    cycle(vin(0, 1, 0, 8'h00, 0, 0, 8'h00), 1);
    for (int i = 0; i < 5; i++) cycle(beat(8'(i), 0), 1);
    @(negedge clk);
    bus.load_valid = 1;
    #2 rst_n = 0;
    #1;
    chk("mrst_prog_len",   bus.prog_len,    0);
    chk("mrst_load_ready", bus.load_ready,  0);
    chk("mrst_loaded",     bus.loaded,      0);
    chk("mrst_instr",      bus.instruction, FILL);
    model_reset();
    @(negedge clk);
    bus.load_valid = 0;
    rst_n = 1;
    cycle(fetch(8'd0), 1);
    chk("mrst_fetch0", bus.instruction, FILL);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      in_t x;
      x.clr = ($urandom % 80) == 0;
      x.st  = ($urandom % 25) == 0;
      x.v   = ($urandom % 4) != 0;
      x.d   = 8'($urandom);
      x.lst = ($urandom % 20) == 0;
      x.fr  = ($urandom % 2) == 1;
      x.fa  = (($urandom % 10) == 0) ? 8'($urandom) : 8'($urandom % 40);
      cycle(x, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
